// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle for mux2_rr_arbiter: two requester ports (A, B), one output
// port and the busy flag. The arbiter uses the slave modport, the driver side uses master.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 8
);

  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_last;
  logic             a_ready;

  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_last;
  logic             b_ready;

  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_sel;
  logic             y_last;
  logic             y_ready;

  logic             busy;

  modport slave (
    input  a_valid, a_data, a_last,
    output a_ready,
    input  b_valid, b_data, b_last,
    output b_ready,
    output y_valid, y_data, y_sel, y_last,
    input  y_ready,
    output busy
  );

  modport master (
    output a_valid, a_data, a_last,
    input  a_ready,
    output b_valid, b_data, b_last,
    input  b_ready,
    input  y_valid, y_data, y_sel, y_last,
    output y_ready,
    input  busy
  );

endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one 2:1 mux (sel 0=A, 1=B) into a registered output stage.
// Optional macro MUX2_ARB_FIXED_PRIO_EN: IDLE tie-break always grants A instead of round-robin.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mux2_rr_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_e;

  localparam int              CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic            SEL_A    = 1'b0;
  localparam logic            SEL_B    = 1'b1;

  state_e             state_q,     state_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               y_valid_q,   y_valid_d;
  logic [WIDTH-1:0]   y_data_q,    y_data_d;
  logic               y_sel_q,     y_sel_d;
  logic               y_last_q,    y_last_d;
  logic               busy_q,      busy_d;

  logic               a_ready_s;
  logic               b_ready_s;
  logic               out_free_s;
  logic               xfer_s;
  logic               xfer_sel_s;
  logic [WIDTH-1:0]   xfer_data_s;
  logic               xfer_last_s;
  logic               release_s;

  // Grant chosen in IDLE from the requesters that are valid at this edge.
  function automatic state_e pick_grant(input logic av, input logic bv, input logic lg);
    state_e g;
    if (av && bv) begin
`ifdef MUX2_ARB_FIXED_PRIO_EN
      g = GNT_A;
`else
      g = (lg == SEL_B) ? GNT_A : GNT_B;
`endif
    end else if (av) begin
      g = GNT_A;
    end else if (bv) begin
      g = GNT_B;
    end else begin
      g = IDLE;
    end
    return g;
  endfunction

`ifdef MUX2_ARB_FIXED_PRIO_EN
  // last_grant is still kept up to date but plays no role in the fixed tie-break.
  logic fixed_prio_unused_s;
  assign fixed_prio_unused_s = last_grant_q;
`endif

  // Ready toward the granted requester and the selected beat on the shared mux.
  always_comb begin
    out_free_s  = !y_valid_q || bus.y_ready;
    a_ready_s   = 1'b0;
    b_ready_s   = 1'b0;
    xfer_s      = 1'b0;
    xfer_sel_s  = SEL_A;
    xfer_data_s = bus.a_data;
    xfer_last_s = bus.a_last;
    case (state_q)
      GNT_A: begin
        a_ready_s   = out_free_s;
        xfer_s      = bus.a_valid && out_free_s;
        xfer_sel_s  = SEL_A;
        xfer_data_s = bus.a_data;
        xfer_last_s = bus.a_last;
      end
      GNT_B: begin
        b_ready_s   = out_free_s;
        xfer_s      = bus.b_valid && out_free_s;
        xfer_sel_s  = SEL_B;
        xfer_data_s = bus.b_data;
        xfer_last_s = bus.b_last;
      end
      default: begin
        a_ready_s   = 1'b0;
        b_ready_s   = 1'b0;
        xfer_s      = 1'b0;
      end
    endcase
    release_s = xfer_s && (xfer_last_s || (burst_cnt_q == CNT_LAST));
  end

  // Next-state for the grant FSM, burst counter and output stage.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    y_valid_d    = y_valid_q;
    y_data_d     = y_data_q;
    y_sel_d      = y_sel_q;
    y_last_d     = y_last_q;

    case (state_q)
      IDLE: begin
        state_d     = pick_grant(bus.a_valid, bus.b_valid, last_grant_q);
        burst_cnt_d = '0;
      end
      GNT_A, GNT_B: begin
        if (release_s) begin
          state_d      = IDLE;
          last_grant_d = xfer_sel_s;
          burst_cnt_d  = '0;
        end else if (xfer_s) begin
          burst_cnt_d  = burst_cnt_q + CNT_W'(1);
        end else begin
          burst_cnt_d  = burst_cnt_q;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase

    // A fill takes precedence; a drain without a fill empties the stage.
    if (xfer_s) begin
      y_valid_d = 1'b1;
      y_data_d  = xfer_data_s;
      y_sel_d   = xfer_sel_s;
      y_last_d  = xfer_last_s;
    end else if (bus.y_ready) begin
      y_valid_d = 1'b0;
    end else begin
      y_valid_d = y_valid_q;
    end

    busy_d = (state_d != IDLE);
  end

  // All state flops; reset drops the grant and any beat in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= SEL_B;
      burst_cnt_q  <= '0;
      y_valid_q    <= 1'b0;
      y_data_q     <= '0;
      y_sel_q      <= 1'b0;
      y_last_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      y_valid_q    <= y_valid_d;
      y_data_q     <= y_data_d;
      y_sel_q      <= y_sel_d;
      y_last_q     <= y_last_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.a_ready = a_ready_s;
  assign bus.b_ready = b_ready_s;
  assign bus.y_valid = y_valid_q;
  assign bus.y_data  = y_data_q;
  assign bus.y_sel   = y_sel_q;
  assign bus.y_last  = y_last_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed, table-driven bench for mux2_rr_arbiter (WIDTH=8, MAX_BURST=4); one vector per clock cycle.
// Inputs change on the falling edge and outputs are compared 1 time unit later.
module tb_mux2_rr_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mux2_rr_arbiter_if #(.WIDTH(8)) bus ();

  mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [7:0] ad;
    logic       al;
    logic       bv;
    logic [7:0] bd;
    logic       bl;
    logic       yr;
    logic       e_ar;
    logic       e_br;
    logic       e_yv;
    logic [7:0] e_yd;
    logic       e_ys;
    logic       e_yl;
    logic       e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic av, input logic [7:0] ad, input logic al,
                              input logic bv, input logic [7:0] bd, input logic bl,
                              input logic yr, input logic ar, input logic br,
                              input logic yv, input logic [7:0] yd, input logic ys,
                              input logic yl, input logic bz);
    vec_t v;
    v.av = av; v.ad = ad; v.al = al; v.bv = bv; v.bd = bd; v.bl = bl; v.yr = yr;
    v.e_ar = ar; v.e_br = br; v.e_yv = yv; v.e_yd = yd; v.e_ys = ys; v.e_yl = yl;
    v.e_busy = bz;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.a_valid = v.av; bus.a_data = v.ad; bus.a_last = v.al;
    bus.b_valid = v.bv; bus.b_data = v.bd; bus.b_last = v.bl;
    bus.y_ready = v.yr;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_ready"}, -1, 32'(bus.a_ready), 32'd0);
    chk({tag, "_b_ready"}, -1, 32'(bus.b_ready), 32'd0);
    chk({tag, "_y_valid"}, -1, 32'(bus.y_valid), 32'd0);
    chk({tag, "_y_data"},  -1, 32'(bus.y_data),  32'd0);
    chk({tag, "_y_sel"},   -1, 32'(bus.y_sel),   32'd0);
    chk({tag, "_y_last"},  -1, 32'(bus.y_last),  32'd0);
    chk({tag, "_busy"},    -1, 32'(bus.busy),    32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // av ad al bv bd bl yr | ar br yv yd ys yl busy
`ifdef MUX2_ARB_FIXED_PRIO_EN
    add(1'b1, 8'h10, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h10, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h11, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h12, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h13, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h14, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h14, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h15, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h14, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h16, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h17, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h16, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h18, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h17, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h18, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h19, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h18, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h19, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`else
    // contention: 4 A beats, IDLE, 4 B beats, IDLE, back to A
    add(1'b1, 8'h10, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h10, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h11, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h12, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h13, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h14, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 1'b0);
    add(1'b1, 8'h14, 1'b0, 1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h14, 1'b0, 1'b1, 8'h21, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 1'b1, 1'b0, 1'b1);
    add(1'b1, 8'h14, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h21, 1'b1, 1'b0, 1'b1);
    add(1'b1, 8'h14, 1'b0, 1'b1, 8'h23, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1);
    add(1'b1, 8'hA1, 1'b0, 1'b1, 8'h24, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h23, 1'b1, 1'b0, 1'b0);
    // early last: A ends after 0xA2 while B waits
    add(1'b1, 8'hA1, 1'b0, 1'b1, 8'h24, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'hA2, 1'b1, 1'b1, 8'h24, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'hA3, 1'b0, 1'b1, 8'h30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0);
    // mid-burst idle: B drops valid for 5 cycles, A waiting
    add(1'b1, 8'hA3, 1'b0, 1'b1, 8'h30, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'hA3, 1'b0, 1'b0, 8'h31, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h30, 1'b1, 1'b0, 1'b1);
    add(1'b1, 8'hA3, 1'b0, 1'b0, 8'h31, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'hA3, 1'b0, 1'b0, 8'h31, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'hA3, 1'b0, 1'b0, 8'h31, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'hA3, 1'b0, 1'b0, 8'h31, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'hA3, 1'b0, 1'b1, 8'h31, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'hA3, 1'b0, 1'b1, 8'h32, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h31, 1'b1, 1'b0, 1'b1);
    add(1'b1, 8'hA3, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h32, 1'b1, 1'b0, 1'b1);
    add(1'b1, 8'h55, 1'b0, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    // backpressure: 0x55 held for 3 cycles, then drain+fill with no bubble
    add(1'b1, 8'h55, 1'b0, 1'b1, 8'h34, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h56, 1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h56, 1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h56, 1'b0, 1'b1, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h56, 1'b0, 1'b1, 8'h34, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    add(1'b1, 8'h57, 1'b1, 1'b1, 8'h34, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h56, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h57, 1'b0, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`endif

    // Reset held with both requesters valid: everything stays at zero.
    rst_n = 1'b0;
    drive(vecs[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk_all_zero("reset_hold");

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      chk("a_ready", i, 32'(bus.a_ready), 32'(vecs[i].e_ar));
      chk("b_ready", i, 32'(bus.b_ready), 32'(vecs[i].e_br));
      chk("y_valid", i, 32'(bus.y_valid), 32'(vecs[i].e_yv));
      chk("busy",    i, 32'(bus.busy),    32'(vecs[i].e_busy));
      if (vecs[i].e_yv) begin
        chk("y_data", i, 32'(bus.y_data), 32'(vecs[i].e_yd));
        chk("y_sel",  i, 32'(bus.y_sel),  32'(vecs[i].e_ys));
        chk("y_last", i, 32'(bus.y_last), 32'(vecs[i].e_yl));
      end
      @(negedge clk);
    end

    // Asynchronous reset mid-burst discards the held beat and the grant.
    bus.a_valid = 1'b1; bus.a_data = 8'h77; bus.a_last = 1'b0;
    bus.b_valid = 1'b0; bus.b_data = 8'h00; bus.b_last = 1'b0;
    bus.y_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_busy",    -1, 32'(bus.busy),    32'd1);
    chk("pre_rst_y_valid", -1, 32'(bus.y_valid), 32'd1);
    chk("pre_rst_y_data",  -1, 32'(bus.y_data),  32'h77);
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    bus.a_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_all_zero("post_rst_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
